// File: rtl/seq_pkg.sv
// Types and defaults for the 1011 sequence-detector front end,
// shared with the detector testbenches.
package seq_pkg;

    typedef enum logic {IDLE, SHIFT} piso_st_t;

    localparam int unsigned WIDTH_DEF     = 8;
    localparam bit          MSB_FIRST_DEF = 1'b1;

endpackage

// File: rtl/piso_hold_reg.sv
// One-entry holding buffer in front of the PISO shift register.
// It is filled on accept_i and emptied on take_i.
module piso_hold_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             accept_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             take_i,
    output logic [WIDTH-1:0] hold_o,
    output logic             full_o
);

    logic [WIDTH-1:0] hold_q, hold_d;
    logic             full_q, full_d;

    // accept_i is only raised while empty and take_i only while full,
    // so the two never collide.
    always_comb begin
        hold_d = hold_q;
        full_d = full_q;
        if (take_i) begin
            full_d = 1'b0;
        end
        if (accept_i) begin
            hold_d = data_i;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q <= '0;
            full_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            full_q <= full_d;
        end
    end

    assign hold_o = hold_q;
    assign full_o = full_q;

endmodule

// File: rtl/seq_piso_feeder.sv
// Parallel-in/serial-out feeder for the 1011 detector: buffers one word
// and streams words gaplessly, one bit per clock, qualified by so_valid.
module seq_piso_feeder
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEF,
    parameter bit          MSB_FIRST = MSB_FIRST_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             so,
    output logic             so_valid,
    output logic             word_done
);

    localparam int unsigned     CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    piso_st_t         st_q, st_d;
    logic [WIDTH-1:0] sreg_q, sreg_d, sreg_shifted;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic             accept;
    logic             take;
    logic             last_bit;

    assign din_ready = !hold_full;
    assign accept    = din_valid && din_ready;

    piso_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk      (clk),
        .reset    (reset),
        .accept_i (accept),
        .data_i   (din),
        .take_i   (take),
        .hold_o   (hold),
        .full_o   (hold_full)
    );

    // Zeros fill the vacated end; the output end is always the next bit.
    assign sreg_shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};
    assign last_bit     = (st_q == SHIFT) && (cnt_q == CntLast);

    always_comb begin
        st_d   = st_q;
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        take   = 1'b0;
        unique case (st_q)
            IDLE: begin
                if (hold_full) begin
                    sreg_d = hold;
                    cnt_d  = '0;
                    take   = 1'b1;
                    st_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    if (hold_full) begin
                        sreg_d = hold;
                        take   = 1'b1;
                    end else begin
                        sreg_d = sreg_shifted;
                        st_d   = IDLE;
                    end
                end else begin
                    sreg_d = sreg_shifted;
                    cnt_d  = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q   <= IDLE;
            sreg_q <= '0;
            cnt_q  <= '0;
        end else begin
            st_q   <= st_d;
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
        end
    end

    assign so_valid  = (st_q == SHIFT);
    assign so        = so_valid && (MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0]);
    assign word_done = last_bit;

endmodule

// File: tb/tb_seq_piso_feeder.sv
// Directed bench for seq_piso_feeder: MSB-first, LSB-first and WIDTH=2
// instances, with per-cycle output logs compared against hand-built streams.
module tb_seq_piso_feeder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] din0 = '0;
    logic [7:0] din1 = '0;
    logic [1:0] din2 = '0;
    logic [2:0] dv = '0;
    logic [2:0] rdy_w, so_w, sov_w, done_w;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    logic [2:0] so_log  [0:1023];
    logic [2:0] v_log   [0:1023];
    logic [2:0] d_log   [0:1023];
    logic [2:0] rdy_log [0:1023];

    seq_piso_feeder #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk(clk), .reset(reset), .din(din0), .din_valid(dv[0]), .din_ready(rdy_w[0]),
        .so(so_w[0]), .so_valid(sov_w[0]), .word_done(done_w[0])
    );
    seq_piso_feeder #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk(clk), .reset(reset), .din(din1), .din_valid(dv[1]), .din_ready(rdy_w[1]),
        .so(so_w[1]), .so_valid(sov_w[1]), .word_done(done_w[1])
    );
    seq_piso_feeder #(.WIDTH(2), .MSB_FIRST(1'b1)) u_dut_w2 (
        .clk(clk), .reset(reset), .din(din2), .din_valid(dv[2]), .din_ready(rdy_w[2]),
        .so(so_w[2]), .so_valid(sov_w[2]), .word_done(done_w[2])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Entry n holds the outputs seen during the cycle after edge n.
    always @(posedge clk) begin
        #1;
        if (cyc < 1024) begin
            so_log[cyc]  <= so_w;
            v_log[cyc]   <= sov_w;
            d_log[cyc]   <= done_w;
            rdy_log[cyc] <= rdy_w;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Holds the word on din until a handshake edge; returns that edge's index.
    task automatic send(input int d, input logic [7:0] w, output int acc);
        logic r;
        acc = -1;
        case (d)
            0: din0 = w;
            1: din1 = w;
            default: din2 = w[1:0];
        endcase
        dv[d] = 1'b1;
        for (int n = 0; n < 64; n++) begin
            r = rdy_w[d];
            @(posedge clk);
            #1;
            if (r) begin
                acc = cyc;
                break;
            end
        end
        dv[d] = 1'b0;
        if (acc < 0) check_eq("send_timeout", 32'd0, 32'd1);
    endtask

    // bits/done: first bit on the wire sits at position n-1.
    task automatic check_stream(input string tag, input int d, input int start, input int n,
                                input logic [31:0] bits, input logic [31:0] done);
        check_eq($sformatf("%s_pre_valid", tag), 32'(v_log[start-1][d]), 32'd0);
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s_valid%0d", tag, i), 32'(v_log[start+i][d]), 32'd1);
            check_eq($sformatf("%s_so%0d", tag, i), 32'(so_log[start+i][d]), 32'(bits[n-1-i]));
            check_eq($sformatf("%s_done%0d", tag, i), 32'(d_log[start+i][d]), 32'(done[n-1-i]));
        end
        check_eq($sformatf("%s_post_valid", tag), 32'(v_log[start+n][d]), 32'd0);
        check_eq($sformatf("%s_post_so", tag), 32'(so_log[start+n][d]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, b, c;
        step(3);
        reset = 1'b0;
        #1;
        check_eq("rst_so", 32'(so_w), 32'd0);
        check_eq("rst_so_valid", 32'(sov_w), 32'd0);
        check_eq("rst_word_done", 32'(done_w), 32'd0);
        check_eq("rst_din_ready", 32'(rdy_w), 32'h7);
        step(2);

        // Single word, MSB first; first bit the cycle after the load edge.
        send(0, 8'hB0, a);
        check_eq("b0_ready_after_accept", 32'(rdy_w[0]), 32'd0);
        step(12);
        check_stream("b0", 0, a + 1, 8, 32'hB0, 32'h01);
        check_eq("b0_ready_after_load", 32'(rdy_log[a+1][0]), 32'd1);

        // BB, 0B back to back, then A5 held while the buffer is full.
        send(0, 8'hBB, a);
        send(0, 8'h0B, b);
        send(0, 8'hA5, c);
        check_eq("b2b_second_acc", 32'(b), 32'(a + 2));
        check_eq("b2b_third_acc", 32'(c), 32'(a + 10));
        step(20);
        check_stream("b2b", 0, a + 1, 24, 32'hBB0BA5, 32'h010101);
        for (int i = a + 2; i <= a + 8; i++) begin
            check_eq($sformatf("b2b_ready_low%0d", i - a), 32'(rdy_log[i][0]), 32'd0);
        end
        check_eq("b2b_ready_reload", 32'(rdy_log[a+9][0]), 32'd1);

        // LSB first: 0D shifts out as 1,0,1,1,0,0,0,0.
        send(1, 8'h0D, a);
        step(12);
        check_stream("lsb", 1, a + 1, 8, 32'hB0, 32'h01);

        // WIDTH=2 streaming.
        send(2, 8'h02, a);
        send(2, 8'h03, b);
        step(6);
        check_stream("w2", 2, a + 1, 4, 32'hB, 32'h5);

        // Reset at bit 3 of FF with 3C waiting in the buffer.
        send(0, 8'hFF, a);
        send(0, 8'h3C, b);
        step(a + 4 - cyc);
        check_eq("rst_mid_so_before", 32'(so_w[0]), 32'd1);
        check_eq("rst_mid_ready_before", 32'(rdy_w[0]), 32'd0);
        reset = 1'b1;
        #1;
        check_eq("rst_mid_so", 32'(so_w[0]), 32'd0);
        check_eq("rst_mid_so_valid", 32'(sov_w[0]), 32'd0);
        check_eq("rst_mid_done", 32'(done_w[0]), 32'd0);
        check_eq("rst_mid_ready", 32'(rdy_w[0]), 32'd1);
        step(1);
        reset = 1'b0;
        a = cyc;
        step(12);
        for (int i = a; i < a + 12; i++) begin
            check_eq($sformatf("rst_residual%0d", i - a), 32'(v_log[i][0]), 32'd0);
        end
        send(0, 8'h96, a);
        step(12);
        check_stream("post_rst", 0, a + 1, 8, 32'h96, 32'h01);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_piso_feeder.md
# seq_piso_feeder

Parallel-in/serial-out front end for the overlapping 1011 sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and drives them one bit per clock onto the detector's PI input. A one-word holding register lets consecutive words stream with no idle bit between them. `so_valid` qualifies each bit for monitors and counters placed after the detector.

## Interface
Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = shift bit WIDTH-1 first; 0 = shift bit 0 first.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- din  input  WIDTH  parallel word.
- din_valid  input  1  `din` is valid this cycle.
- din_ready  output  1  holding register is empty; a word is accepted when `din_valid && din_ready` at a rising edge.
- so  output  1  serial bit; connects to the detector's PI.
- so_valid  output  1  `so` carries a word bit this cycle.
- word_done  output  1  one-cycle pulse coincident with the last bit of a word.

## Operation
- State:
  - `hold`[WIDTH] and `hold_full`: one-entry buffer.
  - `sreg`[WIDTH]: shift register.
  - `cnt`[$clog2(WIDTH)]: bit index.
  - FSM `st` ∈ {IDLE, SHIFT}.
- `din_ready = !hold_full`. This is a registered-state function, so no word is accepted in a cycle where `hold` is occupied.
- Accept: on a handshake edge, `hold <= din` and `hold_full <= 1`.
- IDLE:
  - If `hold_full`: `sreg <= hold`, `hold_full <= 0`, `cnt <= 0`, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - Outputs: `so` = sreg[WIDTH-1] when MSB_FIRST=1, else sreg[0]. `so_valid = 1`.
  - Each edge: shift sreg toward the output end, `cnt <= cnt+1`.
  - When `cnt == WIDTH-1`, `word_done = 1` (combinational from state).
    - If `hold_full`: reload `sreg <= hold`, `cnt <= 0`, clear `hold_full`, stay in SHIFT. This is the gapless case.
    - Otherwise go to IDLE.
- IDLE outputs: `so = 0`, `so_valid = 0`, `word_done = 0`.
  - The detector keeps running on these zeros. The block never resets the detector.
- Fill zeros enter the vacated end of `sreg`. No arithmetic is performed. `cnt` never exceeds WIDTH-1.

## Timing
- Reset values: `so = 0`, `so_valid = 0`, `word_done = 0`, `din_ready = 1`, `st = IDLE`, `cnt = 0`, `hold_full = 0`, `sreg = 0`.
- Latency: a word accepted at edge k enters `sreg` at edge k+1. Its first bit is on `so` during the cycle after edge k+1, and its last bit during the cycle after edge k+WIDTH.
- `din_ready` rises the cycle after `hold` transfers into `sreg`. A word accepted during SHIFT therefore waits at most WIDTH-1 cycles before it shifts.
- Sustained throughput is one word per WIDTH cycles with `so_valid` continuously high.
- Last bit with `hold_full` set: no gap. `so_valid` stays 1 and `word_done` pulses once per word.
- `din_valid` while `din_ready = 0`: the word is not accepted and `hold` is unchanged. The source must hold `din`/`din_valid` until a handshake occurs.
- Reset mid-word: all outputs go to their reset values immediately, asynchronously. Partially shifted and held words are discarded.

## Structure
- Package `seq_pkg`:
  - `typedef enum logic {IDLE, SHIFT} piso_st_t`.
  - Localparam defaults WIDTH_DEF=8 and MSB_FIRST_DEF=1, shared with the detector testbenches.
- One sub-module: `piso_hold_reg`, the one-entry buffer (`hold`, `hold_full`, accept/take ports, async reset).
- The FSM, `sreg` and `cnt` stay in the top module.

## Test plan
- Reset release, then a single word 8'hB0 (MSB_FIRST=1) → `so` = 1,0,1,1,0,0,0,0 on 8 consecutive `so_valid` cycles. First bit 2 cycles after acceptance, `word_done` on the 8th bit. The detector PO pulses once, one cycle after the 4th bit.
- Back-to-back 8'hBB then 8'h0B, second word offered while the first is shifting → 16 contiguous `so_valid` cycles carrying 10111011_00001011. Exactly two `word_done` pulses. `din_ready` stays low from the second handshake until the reload edge.
- `din_valid` held high with a third word while `hold_full` → `din_ready = 0` and no acceptance until the reload. The third word appears immediately after the second, with no gap and no duplicate.
- MSB_FIRST=0, word 8'h0D → `so` = 1,0,1,1,0,0,0,0.
- `reset` asserted at bit 3 of 8'hFF with a word pending in `hold` → within the same cycle `so = 0`, `so_valid = 0`, `din_ready = 1`. After release, no residual bits appear and the next word shifts cleanly.
- WIDTH=2, words 2'b10, 2'b11 streamed → `so` = 1,0,1,1 contiguous, with `word_done` on the 2nd and 4th bits.
